network_ejector_vc: RTL

Parametrised multi-virtual-channel ejection unit between a NoC router local output port and the attached node. Incoming flits are buffered per VC under credit-based flow control. Whole packets are selected round-robin and delivered wormhole-style (no interleaving) on a valid/ready stream. Protocol violations are flagged and a delivered-packet count is kept.

---
 rtl/network_ejector_pkg.sv | 38 +++
 rtl/network_ejector_vc_fifo.sv | 72 +++++++
 rtl/network_ejector_vc.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/network_ejector_pkg.sv
// network_ejector_pkg
// Shared types and helpers for the NoC ejection unit.
//   flit_type_e     : flit framing code carried alongside each payload
//   ejector_state_e : output FSM state (IDLE between packets, LOCKED inside one)
//   flit_entry_t    : buffer entry layout {type, payload} at the default width;
//                     the top re-declares the same layout at its own FlitWidth
package network_ejector_pkg;

    localparam int unsigned FLIT_WIDTH_DEFAULT = 64;

    typedef enum logic [1:0] {
        HEAD      = 2'd0,
        BODY      = 2'd1,
        TAIL      = 2'd2,
        HEAD_TAIL = 2'd3
    } flit_type_e;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } ejector_state_e;

    typedef struct packed {
        flit_type_e                    ftype;
        logic [FLIT_WIDTH_DEFAULT-1:0] payload;
    } flit_entry_t;

    // A flit that may legally open a packet.
    function automatic logic is_head(input flit_type_e t);
        return (t == HEAD) || (t == HEAD_TAIL);
    endfunction

    // A flit that closes a packet.
    function automatic logic is_last(input flit_type_e t);
        return (t == TAIL) || (t == HEAD_TAIL);
    endfunction

endpackage

// File: rtl/network_ejector_vc_fifo.sv
// network_ejector_vc_fifo
// Per-VC flit buffer: circular FIFO with occupancy counter.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wdata (ignored when full unless popped this cycle)
//   pop      : remove head entry (ignored when empty)
//   wdata    : entry to write
//   full     : Depth entries held
//   empty    : no entries held
//   head     : oldest entry (valid only when not empty)
module network_ejector_vc_fifo
    import network_ejector_pkg::*;
#(
    parameter int unsigned Width = 66,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [Width-1:0] head
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] FullCount = (PtrW+1)'(Depth);

    logic [Width-1:0] mem_r [Depth];
    logic [PtrW-1:0]  wptr_r;
    logic [PtrW-1:0]  rptr_r;
    logic [PtrW:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (count_r == FullCount);
    assign empty = (count_r == {(PtrW+1){1'b0}});
    assign head  = mem_r[rptr_r];

    // A full buffer still takes a write when its head leaves in the same cycle.
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Storage array; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wptr_r] <= wdata;
        end
    end

    // Pointers and occupancy; Depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r  <= {PtrW{1'b0}};
            rptr_r  <= {PtrW{1'b0}};
            count_r <= {(PtrW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wptr_r <= wptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/network_ejector_vc.sv
// network_ejector_vc
// Multi-VC ejection unit: buffers flits per VC under credit flow control and
// delivers whole packets round-robin, wormhole-style, on a valid/ready stream.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   flit_valid_i/flit_i/flit_type_i/flit_vc_i : ingress flit
//   credit_o            : per-VC pulse in the cycle a flit leaves its buffer
//   data_o/data_vc_o/data_last_o/data_valid_o, data_ready_i : egress stream
//   error_o             : sticky overflow / framing / bad-VC flag
//   pkt_count_o         : wrapping count of delivered packets
module network_ejector_vc
    import network_ejector_pkg::*;
#(
    parameter int unsigned FlitWidth   = 64,
    parameter int unsigned NumVC       = 4,
    parameter int unsigned BufferDepth = 4,
    parameter int unsigned CountWidth  = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flit_valid_i,
    input  logic [FlitWidth-1:0]     flit_i,
    input  logic [1:0]               flit_type_i,
    input  logic [$clog2(NumVC)-1:0] flit_vc_i,
    output logic [NumVC-1:0]         credit_o,
    output logic [FlitWidth-1:0]     data_o,
    output logic [$clog2(NumVC)-1:0] data_vc_o,
    output logic                     data_last_o,
    output logic                     data_valid_o,
    input  logic                     data_ready_i,
    output logic                     error_o,
    output logic [CountWidth-1:0]    pkt_count_o
);

    localparam int unsigned VcW = $clog2(NumVC);

    typedef struct packed {
        flit_type_e           ftype;
        logic [FlitWidth-1:0] payload;
    } entry_t;

    ejector_state_e        state_r;
    logic [VcW-1:0]        lock_vc_r;
    logic [VcW-1:0]        rr_ptr_r;
    logic                  first_r;
    logic                  error_r;
    logic [CountWidth-1:0] pkt_count_r;

    entry_t                wr_entry_s;
    entry_t                head_s [NumVC];
    entry_t                head_entry_s;
    logic [NumVC-1:0]      full_s;
    logic [NumVC-1:0]      empty_s;
    logic [NumVC-1:0]      push_s;
    logic [NumVC-1:0]      pop_s;
    logic                  valid_s;
    logic                  hs_s;
    logic                  last_s;
    logic                  grant_valid_s;
    logic [VcW-1:0]        grant_vc_s;
    logic [VcW:0]          cand_s;
    logic                  vc_bad_s;
    logic                  drop_s;
    logic                  frame_err_s;

    assign wr_entry_s = '{ftype: flit_type_e'(flit_type_i), payload: flit_i};

    for (genvar v = 0; v < NumVC; v++) begin : g_vc
        assign push_s[v] = flit_valid_i & (flit_vc_i == VcW'(v));

        network_ejector_vc_fifo #(
            .Width ($bits(entry_t)),
            .Depth (BufferDepth)
        ) u_fifo (
            .clk   (clk_i),
            .rst   (rst_i),
            .push  (push_s[v]),
            .pop   (pop_s[v]),
            .wdata (wr_entry_s),
            .full  (full_s[v]),
            .empty (empty_s[v]),
            .head  (head_s[v])
        );
    end

    // Present the locked VC's head entry and derive handshake, pop and credit.
    always_comb begin
        head_entry_s = head_s[lock_vc_r];
        valid_s      = (state_r == LOCKED) & ~empty_s[lock_vc_r];
        hs_s         = valid_s & data_ready_i;
        last_s       = is_last(head_entry_s.ftype);
        pop_s        = {NumVC{1'b0}};
        if (hs_s) begin
            pop_s[lock_vc_r] = 1'b1;
        end else begin
            pop_s = {NumVC{1'b0}};
        end
    end

    // Outputs read zero whenever nothing is being offered.
    assign data_valid_o = valid_s;
    assign data_o       = valid_s ? head_entry_s.payload : {FlitWidth{1'b0}};
    assign data_vc_o    = valid_s ? lock_vc_r : {VcW{1'b0}};
    assign data_last_o  = valid_s & last_s;
    assign credit_o     = pop_s;
    assign error_o      = error_r;
    assign pkt_count_o  = pkt_count_r;

    // Round-robin search: first non-empty VC at or above rr_ptr, wrapping.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_vc_s    = {VcW{1'b0}};
        cand_s        = {(VcW+1){1'b0}};
        for (int i = 0; i < NumVC; i++) begin
            cand_s = {1'b0, rr_ptr_r} + (VcW+1)'(i);
            if (cand_s >= (VcW+1)'(NumVC)) begin
                cand_s = cand_s - (VcW+1)'(NumVC);
            end else begin
                cand_s = cand_s;
            end
            if (!grant_valid_s && !empty_s[cand_s[VcW-1:0]]) begin
                grant_valid_s = 1'b1;
                grant_vc_s    = cand_s[VcW-1:0];
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    // Protocol checks: dropped ingress flit, and out-of-order framing at egress.
    always_comb begin
        vc_bad_s = ({1'b0, flit_vc_i} >= (VcW+1)'(NumVC));
        drop_s   = flit_valid_i &
                   (vc_bad_s | (full_s[flit_vc_i] & ~pop_s[flit_vc_i]));
        if (hs_s) begin
            frame_err_s = first_r ? ~is_head(head_entry_s.ftype)
                                  :  is_head(head_entry_s.ftype);
        end else begin
            frame_err_s = 1'b0;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            error_r <= 1'b0;
        end else begin
            error_r <= error_r | drop_s | frame_err_s;
        end
    end

    // Packet FSM: lock onto a granted VC, release on tail handshake.
    // first_r marks that the next delivered flit must open a packet.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            lock_vc_r   <= {VcW{1'b0}};
            rr_ptr_r    <= {VcW{1'b0}};
            first_r     <= 1'b1;
            pkt_count_r <= {CountWidth{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        lock_vc_r <= grant_vc_s;
                        first_r   <= 1'b1;
                        state_r   <= LOCKED;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                LOCKED: begin
                    if (hs_s) begin
                        first_r <= last_s;
                        if (last_s) begin
                            state_r     <= IDLE;
                            rr_ptr_r    <= (lock_vc_r == VcW'(NumVC - 1)) ?
                                           {VcW{1'b0}} : lock_vc_r + 1'b1;
                            pkt_count_r <= pkt_count_r + 1'b1;
                        end else begin
                            state_r <= LOCKED;
                        end
                    end else begin
                        state_r <= LOCKED;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule
